// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants for the pipelined carry-lookahead adder.
// Chunk width is derived here so the top and the slices agree.
package pipelined_cla_adder_pkg;

  localparam int DEF_WIDTH  = 64;
  localparam int DEF_STAGES = 4;

  function automatic int chunk_width(input int w, input int s);
    return w / s;
  endfunction

  localparam int DEF_CW = chunk_width(DEF_WIDTH, DEF_STAGES);

endpackage

// File: rtl/pipelined_cla_adder_cla_chunk.sv
// Combinational CW-bit carry-lookahead slice.
// Every carry is a flat sum of generate/propagate products.
module cla_chunk
  import pipelined_cla_adder_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic [CW-1:0] X,
  input  logic [CW-1:0] Y,
  input  logic          CarryIn,
  output logic [CW-1:0] Sum,
  output logic          CarryOut
);

  logic [CW-1:0] g;
  logic [CW-1:0] p;
  logic [CW:0]   c;

  assign g = X & Y;
  assign p = X ^ Y;

  always_comb begin
    logic term;
    logic run;
    term = 1'b0;
    run  = 1'b0;
    c    = '0;
    c[0] = CarryIn;
    for (int i = 0; i < CW; i++) begin
      term = g[i];
      run  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (run & g[j]);
        run  = run & p[j];
      end
      c[i+1] = term | (run & CarryIn);
    end
  end

  assign Sum      = p ^ c[CW-1:0];
  assign CarryOut = c[CW];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined add/subtract: one CW-bit chunk resolved per stage,
// unconsumed operand bits and finished sum bits travel alongside.
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             CarryIn,
  input  logic             Sub,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] Sum,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             OutValid,
  input  logic             OutReady
);

  localparam int CW = chunk_width(WIDTH, STAGES);

  if (WIDTH % STAGES != 0) begin : g_bad_split
    $error("WIDTH must be a multiple of STAGES");
  end

  logic             adv;
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic [WIDTH-1:0] s_n [STAGES];
  logic             c_d [STAGES];
  logic             c_n [STAGES];
  logic             v_d [STAGES];
  logic [CW-1:0]    part [STAGES];

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];

  assign adv     = !v_q[STAGES-1] || OutReady;
  assign InReady = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    if (k == 0) begin : g_head
      // Subtraction folds into the operands before stage 0.
      assign a_d[k] = X;
      assign b_d[k] = Y ^ {WIDTH{Sub}};
      assign c_d[k] = CarryIn ^ Sub;
      assign s_d[k] = '0;
      assign v_d[k] = InValid;
    end else begin : g_body
      assign a_d[k] = a_q[k-1];
      assign b_d[k] = b_q[k-1];
      assign c_d[k] = c_q[k-1];
      assign s_d[k] = s_q[k-1];
      assign v_d[k] = v_q[k-1];
    end

    cla_chunk #(.CW(CW)) u_cla (
      .X        (a_d[k][k*CW +: CW]),
      .Y        (b_d[k][k*CW +: CW]),
      .CarryIn  (c_d[k]),
      .Sum      (part[k]),
      .CarryOut (c_n[k])
    );

    assign s_n[k] = s_d[k] | (WIDTH'(part[k]) << (k * CW));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_d[k];
        if (v_d[k]) begin
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
          s_q[k] <= s_n[k];
          c_q[k] <= c_n[k];
        end
      end
    end
  end

  assign Sum      = s_q[STAGES-1];
  assign CarryOut = c_q[STAGES-1];
  assign OutValid = v_q[STAGES-1];
  assign Overflow = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
                 && (s_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, pipeline depth; WIDTH SHALL be divisible by STAGES, so chunk width is CW = WIDTH/STAGES.
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port X  input  WIDTH  operand A.
REQ-006 SHALL have port Y  input  WIDTH  operand B.
REQ-007 SHALL have port CarryIn  input  1  carry-in (borrow-in when Sub=1).
REQ-008 SHALL have port Sub  input  1  mode: 0 add, 1 subtract.
REQ-009 SHALL have port InValid  input  1  operands valid.
REQ-010 SHALL have port InReady  output  1  block accepts operands this cycle.
REQ-011 SHALL have port Sum  output  WIDTH  result.
REQ-012 SHALL have port CarryOut  output  1  carry out of MSB.
REQ-013 SHALL have port Overflow  output  1  two's-complement signed overflow.
REQ-014 SHALL have port OutValid  output  1  result valid.
REQ-015 SHALL have port OutReady  input  1  consumer accepts result.

Function
REQ-016 SHALL compute Sum and CarryOut as {CarryOut,Sum} = X + (Y XOR {WIDTH{Sub}}) + (CarryIn XOR Sub), modulo 2^(WIDTH+1).
REQ-017 SHALL set Overflow = 1 iff the effective operands' MSBs are equal and Sum MSB differs from them.
REQ-018 SHALL split the add into STAGES chunks of CW bits; stage k SHALL resolve chunk k with carry-lookahead using the registered carry from stage k-1.
REQ-019 SHALL delay unconsumed operand chunks and pass already-resolved sum chunks through the pipeline registers alongside.
REQ-020 SHALL accept a transfer when InValid && InReady, and SHALL deliver a transfer when OutValid && OutReady.
REQ-021 SHALL use a global advance enable: Adv = !OutValid || OutReady; InReady SHALL equal Adv.
REQ-022 SHALL shift all stages and their valid bits forward by one when Adv=1, and SHALL hold every register when Adv=0.
REQ-023 SHALL present a result exactly STAGES cycles after acceptance when no stall occurs; sustained throughput SHALL be one result per cycle.
REQ-024 SHALL insert a bubble (valid bit 0) into stage 0 when Adv=1 and InValid=0.
REQ-025 SHALL keep Sum, CarryOut, Overflow and OutValid stable while OutValid=1 and OutReady=0.
REQ-026 SHALL accept a new input and deliver the final result in the same cycle when the pipeline is full and OutReady=1.
REQ-027 SHALL compute the STAGES=1 case as a single-cycle registered CLA with identical handshake.
REQ-028 SHALL ignore X, Y, CarryIn and Sub while InValid=0.

Reset
REQ-029 SHALL clear all stage valid bits on Reset=1 at a clock edge, giving OutValid=0 and InReady=1 the following cycle.
REQ-030 SHALL drive Sum=0, CarryOut=0 and Overflow=0 after reset.
REQ-031 SHALL discard in-flight operations when Reset is asserted mid-operation; no result from before reset SHALL appear afterwards.
REQ-032 SHALL ignore a transfer offered in the same cycle as Reset=1.

Structure
REQ-033 SHALL place the default WIDTH and STAGES constants and the chunk-width derivation in a shared adder package.
REQ-034 SHALL instantiate one combinational sub-module, cla_chunk (CW-bit generate/propagate carry-lookahead slice, ports X, Y, CarryIn, Sum, CarryOut), once per stage.
REQ-035 SHALL trap WIDTH % STAGES != 0 at elaboration.

Verification
REQ-036 SHALL check X=2^63, Y=2^63, CarryIn=1, Sub=0 (WIDTH=64) -> Sum=1, CarryOut=1, Overflow=1, after exactly 4 cycles.
REQ-037 SHALL check 231+698, CarryIn=0 -> Sum=929, CarryOut=0; then 999999999+1 -> Sum=1000000000.
REQ-038 SHALL check X=5, Y=7, Sub=1, CarryIn=0 -> Sum=2^64-2, CarryOut=0; then X=7, Y=5 -> Sum=2, CarryOut=1.
REQ-039 SHALL check X=0x7FFF_FFFF_FFFF_FFFF, Y=1, Sub=0 -> Overflow=1, CarryOut=0.
REQ-040 SHALL stream 20 back-to-back operations with OutReady toggled randomly and verify in-order results with none lost or duplicated, and outputs held while stalled.
REQ-041 SHALL assert Reset with 3 operations in flight and verify OutValid=0 and no stale results afterward; the stream SHALL be repeated with STAGES=1 and STAGES=8.
